// File: rtl/sub_window_stats.sv
// Windowed statistics over the signed subtractor difference stream: per window of
// WIN_LEN valid samples, reports sum, min, max and negative-sample count.
module sub_window_stats #(
  parameter int DATA_W  = 5,
  parameter int WIN_LEN = 4,
  parameter int SUM_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validIn,
  input  logic [DATA_W-1:0] diffIn,
  input  logic              clearIn,
  output logic [SUM_W-1:0]  sumOut,
  output logic [DATA_W-1:0] minOut,
  output logic [DATA_W-1:0] maxOut,
  output logic [4:0]        negCountOut,
  output logic              doneOut,
  output logic              busyOut
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                    state_r;
  logic signed [SUM_W-1:0]   sum_r;
  logic signed [DATA_W-1:0]  min_r;
  logic signed [DATA_W-1:0]  max_r;
  logic [4:0]                neg_r;
  logic [4:0]                cnt_r;

  logic signed [DATA_W-1:0]  sample_s;
  logic signed [SUM_W-1:0]   sample_ext_s;
  logic                      is_neg_s;
  logic signed [SUM_W-1:0]   sum_nxt_s;
  logic signed [DATA_W-1:0]  min_nxt_s;
  logic signed [DATA_W-1:0]  max_nxt_s;
  logic [4:0]                neg_nxt_s;
  logic [4:0]                cnt_nxt_s;
  logic                      close_s;

  // Next working values assuming the current sample is accepted; IDLE seeds from the sample alone.
  always_comb begin
    sample_s     = diffIn;
    sample_ext_s = {{(SUM_W-DATA_W){diffIn[DATA_W-1]}}, diffIn};
    is_neg_s     = diffIn[DATA_W-1];
    sum_nxt_s    = sample_ext_s;
    min_nxt_s    = sample_s;
    max_nxt_s    = sample_s;
    neg_nxt_s    = {4'b0000, is_neg_s};
    cnt_nxt_s    = 5'd1;
    case (state_r)
      IDLE: begin
        sum_nxt_s = sample_ext_s;
        min_nxt_s = sample_s;
        max_nxt_s = sample_s;
        neg_nxt_s = {4'b0000, is_neg_s};
        cnt_nxt_s = 5'd1;
      end
      ACCUM: begin
        sum_nxt_s = sum_r + sample_ext_s;
        if (sample_s < min_r) begin
          min_nxt_s = sample_s;
        end else begin
          min_nxt_s = min_r;
        end
        if (sample_s > max_r) begin
          max_nxt_s = sample_s;
        end else begin
          max_nxt_s = max_r;
        end
        neg_nxt_s = neg_r + {4'b0000, is_neg_s};
        cnt_nxt_s = cnt_r + 5'd1;
      end
      default: begin
        sum_nxt_s = sample_ext_s;
        min_nxt_s = sample_s;
        max_nxt_s = sample_s;
        neg_nxt_s = {4'b0000, is_neg_s};
        cnt_nxt_s = 5'd1;
      end
    endcase
    close_s = validIn && (cnt_nxt_s == 5'(WIN_LEN));
  end

  // Window FSM, working accumulators and registered results; clear beats a same-cycle sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sum_r       <= '0;
      min_r       <= '0;
      max_r       <= '0;
      neg_r       <= 5'd0;
      cnt_r       <= 5'd0;
      sumOut      <= '0;
      minOut      <= '0;
      maxOut      <= '0;
      negCountOut <= 5'd0;
      doneOut     <= 1'b0;
    end else if (clearIn) begin
      state_r <= IDLE;
      sum_r   <= '0;
      min_r   <= '0;
      max_r   <= '0;
      neg_r   <= 5'd0;
      cnt_r   <= 5'd0;
      doneOut <= 1'b0;
    end else if (close_s) begin
      state_r     <= IDLE;
      sum_r       <= '0;
      min_r       <= '0;
      max_r       <= '0;
      neg_r       <= 5'd0;
      cnt_r       <= 5'd0;
      sumOut      <= sum_nxt_s;
      minOut      <= min_nxt_s;
      maxOut      <= max_nxt_s;
      negCountOut <= neg_nxt_s;
      doneOut     <= 1'b1;
    end else if (validIn) begin
      state_r <= ACCUM;
      sum_r   <= sum_nxt_s;
      min_r   <= min_nxt_s;
      max_r   <= max_nxt_s;
      neg_r   <= neg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      doneOut <= 1'b0;
    end else begin
      doneOut <= 1'b0;
    end
  end

  assign busyOut = (state_r == ACCUM);

endmodule

// File: tb/tb_sub_window_stats.sv
// Directed-vector bench for sub_window_stats with WIN_LEN=4; expected values hand-computed.
module tb_sub_window_stats;

  logic       clk;
  logic       rst_n;
  logic       validIn;
  logic [4:0] diffIn;
  logic       clearIn;
  logic [7:0] sumOut;
  logic [4:0] minOut;
  logic [4:0] maxOut;
  logic [4:0] negCountOut;
  logic       doneOut;
  logic       busyOut;

  int n_checks = 0;
  int n_fail   = 0;

  sub_window_stats #(.DATA_W(5), .WIN_LEN(4), .SUM_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .validIn     (validIn),
    .diffIn      (diffIn),
    .clearIn     (clearIn),
    .sumOut      (sumOut),
    .minOut      (minOut),
    .maxOut      (maxOut),
    .negCountOut (negCountOut),
    .doneOut     (doneOut),
    .busyOut     (busyOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; returns at the next falling edge, after the DUT has sampled them.
  task automatic send(input logic v, input int d, input logic c);
    validIn = v;
    diffIn  = d[4:0];
    clearIn = c;
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int s, input int mn, input int mx, input int ng);
    check_eq({tag, "_done"}, int'(doneOut), 1);
    check_eq({tag, "_sum"}, int'($signed(sumOut)), s);
    check_eq({tag, "_min"}, int'($signed(minOut)), mn);
    check_eq({tag, "_max"}, int'($signed(maxOut)), mx);
    check_eq({tag, "_neg"}, int'(negCountOut), ng);
    check_eq({tag, "_busy"}, int'(busyOut), 0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_sum"}, int'(sumOut), 0);
    check_eq({tag, "_min"}, int'(minOut), 0);
    check_eq({tag, "_max"}, int'(maxOut), 0);
    check_eq({tag, "_neg"}, int'(negCountOut), 0);
    check_eq({tag, "_done"}, int'(doneOut), 0);
    check_eq({tag, "_busy"}, int'(busyOut), 0);
  endtask

  int basic_v[4] = '{4, -3, 0, 7};
  int rst_v[4]   = '{2, -1, -1, 3};

  initial begin
    rst_n = 1'b0; validIn = 1'b0; diffIn = 5'd0; clearIn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic window
    for (int i = 0; i < 4; i++) begin
      send(1'b1, basic_v[i], 1'b0);
      if (i == 0) check_eq("basic_busy1", int'(busyOut), 1);
      if (i < 3) check_eq("basic_nodone", int'(doneOut), 0);
    end
    check_result("basic", 8, -3, 7, 1);
    send(1'b0, 0, 1'b0);
    check_eq("basic_done_drop", int'(doneOut), 0);
    check_eq("basic_hold_sum", int'($signed(sumOut)), 8);

    // Extremes
    for (int i = 0; i < 4; i++) send(1'b1, -16, 1'b0);
    check_result("neg_ext", -64, -16, -16, 4);
    for (int i = 0; i < 4; i++) send(1'b1, 15, 1'b0);
    check_result("pos_ext", 60, 15, 15, 0);
    send(1'b0, 0, 1'b0);

    // Gaps of two idle cycles between samples
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, i, 1'b0);
      if (i == 4) begin
        check_result("gaps", 10, 1, 4, 0);
      end else begin
        check_eq("gaps_nodone", int'(doneOut), 0);
        send(1'b0, 0, 1'b0);
        check_eq("gaps_idle_nodone", int'(doneOut), 0);
        send(1'b0, 0, 1'b0);
        check_eq("gaps_idle_busy", int'(busyOut), 1);
      end
    end
    send(1'b0, 0, 1'b0);
    check_eq("gaps_single_done", int'(doneOut), 0);

    // Back-to-back windows
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, i, 1'b0);
      if (i == 4) check_result("b2b_w1", 10, 1, 4, 0);
      else if (i == 8) check_result("b2b_w2", 26, 5, 8, 0);
      else check_eq("b2b_nodone", int'(doneOut), 0);
    end
    send(1'b0, 0, 1'b0);
    check_eq("b2b_done_drop", int'(doneOut), 0);

    // Clear with a simultaneous valid sample
    send(1'b1, 5, 1'b0);
    send(1'b1, 5, 1'b0);
    send(1'b1, -2, 1'b1);
    check_eq("clr_nodone", int'(doneOut), 0);
    check_eq("clr_busy", int'(busyOut), 0);
    check_eq("clr_hold_sum", int'($signed(sumOut)), 26);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1, 1'b0);
      if (i < 3) begin
        check_eq("clr_w_nodone", int'(doneOut), 0);
        check_eq("clr_w_hold", int'($signed(maxOut)), 8);
      end
    end
    check_result("clr_next", 4, 1, 1, 0);
    send(1'b0, 0, 1'b0);

    // Reset mid-window
    send(1'b1, 3, 1'b0);
    send(1'b1, 3, 1'b0);
    validIn = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(1'b1, rst_v[i], 1'b0);
    check_result("rst_next", 3, -1, 3, 2);

    // Reset while done is high
    validIn = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("rst_done");
    #3;
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
